// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and constants for the iterative divider.
package divider_pkg;
    localparam int DIN_W_DEF = 8;
    localparam logic [63:0] DZ_QUOTIENT = '1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring-division iteration (shift, trial subtract, restore).
module divider_step #(
    parameter int DIN_W = 8
) (
    input  logic [DIN_W-1:0] rem_i,
    input  logic [DIN_W-1:0] quo_i,
    input  logic [DIN_W-1:0] divisor_i,
    output logic [DIN_W-1:0] rem_o,
    output logic [DIN_W-1:0] quo_o
);
    logic [DIN_W:0] shifted;
    logic [DIN_W:0] diff;
    logic           neg;

    // rem < divisor keeps shifted < 2*divisor, so the MSB of diff is the sign
    assign shifted = {rem_i, quo_i[DIN_W-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign neg     = diff[DIN_W];
    assign rem_o   = neg ? shifted[DIN_W-1:0] : diff[DIN_W-1:0];
    assign quo_o   = {quo_i[DIN_W-2:0], ~neg};
endmodule

// File: rtl/divider.sv
// divider: iterative restoring unsigned divider with valid/ready handshakes.
module divider
    import divider_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int CNT_W = $clog2(DIN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [DIN_W-1:0] dividend_i,
    input  logic [DIN_W-1:0] divisor_i,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [DIN_W-1:0] quotient_o,
    output logic [DIN_W-1:0] remainder_o,
    output logic             div_by_zero_o
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIN_W-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [DIN_W-1:0]   step_quo, step_rem;
    logic               dz_q, dz_d;

    divider_step #(.DIN_W(DIN_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: if (start_valid_i) begin
                dvs_d   = divisor_i;
                dz_d    = divisor_i == '0;
                quo_d   = dz_d ? DZ_QUOTIENT[DIN_W-1:0] : dividend_i;
                rem_d   = dz_d ? dividend_i : '0;
                cnt_d   = dz_d ? '0 : CNT_W'(DIN_W);
                state_d = dz_d ? DONE : BUSY;
            end
            BUSY: begin
                quo_d   = step_quo;
                rem_d   = step_rem;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : BUSY;
            end
            DONE: state_d = result_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
        end
    end

    assign start_ready_o  = state_q == IDLE;
    assign result_valid_o = state_q == DONE;
    assign quotient_o     = quo_q;
    assign remainder_o    = rem_q;
    assign div_by_zero_o  = dz_q;
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter DIN_W, default 8, sets dividend, divisor, quotient and remainder width in bits.
REQ-002 Parameter CNT_W, default $clog2(DIN_W+1), sets the width of the iteration counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start_valid_i  input  1  dividend_i/divisor_i carry a valid request.
REQ-006 start_ready_o  output  1  block can accept a request.
REQ-007 dividend_i  input  DIN_W  unsigned dividend.
REQ-008 divisor_i  input  DIN_W  unsigned divisor.
REQ-009 result_valid_o  output  1  quotient_o/remainder_o/div_by_zero_o are valid.
REQ-010 result_ready_i  input  1  consumer accepts the result.
REQ-011 quotient_o  output  DIN_W  unsigned quotient.
REQ-012 remainder_o  output  DIN_W  unsigned remainder.
REQ-013 div_by_zero_o  output  1  the held result came from divisor == 0.

Function
REQ-014 The block SHALL be an iterative restoring unsigned divider with states IDLE, BUSY, DONE; the inverse operation of the team's multiplier.
REQ-015 start_ready_o SHALL be 1 exactly when state == IDLE.
REQ-016 A request SHALL be accepted on a rising edge where start_valid_i && start_ready_o; dividend and divisor are captured into internal registers on that edge.
REQ-017 IDLE->BUSY on accept with divisor_i != 0: remainder register cleared, quotient register loaded with dividend_i, counter loaded with DIN_W.
REQ-018 Each BUSY cycle SHALL shift {rem,quo} left one bit, trial-subtract divisor from the shifted remainder using DIN_W+1 bit arithmetic, keep the difference and set the quotient LSB to 1 if non-negative, otherwise restore and set the LSB to 0, then decrement the counter.
REQ-019 BUSY->DONE on the edge where the counter reaches 0, giving exactly DIN_W BUSY cycles; result_valid_o SHALL be first high DIN_W+1 cycles after the accept edge.
REQ-020 IDLE->DONE on accept with divisor_i == 0: quotient_o = all ones, remainder_o = dividend_i, div_by_zero_o = 1, result_valid_o high 1 cycle after accept.
REQ-021 result_valid_o SHALL be 1 exactly when state == DONE; DONE->IDLE on the edge where result_ready_i == 1.
REQ-022 quotient_o, remainder_o and div_by_zero_o SHALL remain stable while result_valid_o == 1 and result_ready_i == 0.
REQ-023 start_valid_i SHALL be ignored in BUSY and DONE; a new request is accepted no earlier than the cycle after the DONE->IDLE edge (no same-cycle turnaround).
REQ-024 Input changes on dividend_i/divisor_i after the accept edge SHALL NOT affect the result in flight.
REQ-025 Result invariant for divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor, for all DIN_W-bit operands, including the edge cases dividend = 0, divisor = 1 and dividend < divisor.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, with counter, quotient, remainder and div_by_zero registers all 0.
REQ-027 During reset, outputs SHALL be start_ready_o = 1, result_valid_o = 0, quotient_o = 0, remainder_o = 0, div_by_zero_o = 0.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL discard the operation with no result ever presented; the first accept after release starts cleanly.

Structure
REQ-029 The state enum typedef (IDLE, BUSY, DONE) SHALL live in a shared package divider_pkg.
REQ-030 divider_pkg SHALL also hold the default DIN_W constant and the divide-by-zero quotient constant (all ones).
REQ-031 One combinational sub-module, divider_step, SHALL implement the shift/trial-subtract/restore of REQ-018.
REQ-032 divider_step SHALL be instantiated once and reused every BUSY cycle; no unrolled pipeline.

Verification
REQ-033 DIN_W=8, accept 200/7 -> result_valid_o first high 9 cycles after accept: quotient 28, remainder 4, div_by_zero 0.
REQ-034 Accept 255/1 -> quotient 255, remainder 0; accept 3/10 -> quotient 0, remainder 3.
REQ-035 Accept 5/0 -> result_valid_o high 1 cycle after accept: quotient 0xFF, remainder 5, div_by_zero 1.
REQ-036 Result 200/7 with result_ready_i held low 5 cycles -> outputs unchanged all 5 cycles, start_ready_o = 0 throughout; start_valid_i pulsed during BUSY is ignored.
REQ-037 rst_n pulsed low at BUSY cycle 4 of 200/7 -> start_ready_o = 1 and result_valid_o = 0 immediately, no stale result; a following accept of 100/9 -> quotient 11, remainder 1.
REQ-038 Random soak, 10000 operand pairs including 0 and 255, random result_ready_i -> every result satisfies REQ-025 and REQ-020, in request order.
